// File: rtl/axis_i2c_req_arbiter.sv
// Round-robin AXI-Stream arbiter in front of the I2C master command port.
// Grants one requester per packet, then waits for a gap and i2c idle.
//
// Ports:
//   clk_i, arstn_i             main clock, async active-low reset
//   s_axis_*_i / tready_o      N_REQ requester lanes (lane k at k*DATA_WIDTH)
//   m_axis_*                   single stream to the I2C master
//   i2c_busy_i                 I2C transaction in progress, blocks new grants
//   grant_id_o                 current / last granted lane
//   grant_active_o             high while a packet is being passed through
//   timeout_o                  one-cycle pulse when a stalled grant is aborted
// Optional: define AXIS_ARB_TIMEOUT_EN to enable the stall abort counter.

module axis_i2c_req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [N_REQ-1:0]            s_axis_tvalid_i,
  input  logic [N_REQ-1:0]            s_axis_tlast_i,
  output logic [N_REQ-1:0]            s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata_o,
  output logic                        m_axis_tvalid_o,
  output logic                        m_axis_tlast_o,
  input  logic                        m_axis_tready_i,
  input  logic                        i2c_busy_i,
  output logic [$clog2(N_REQ)-1:0]    grant_id_o,
  output logic                        grant_active_o,
  output logic                        timeout_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [IW-1:0]   pick;
  logic            in_grant;
  logic            lane_valid;
  logic            lane_last;
  logic [DATA_WIDTH-1:0] lane_data;
  logic            hs;
  logic            stall_abort;

  assign in_grant   = (state_q == S_GRANT);
  assign lane_valid = s_axis_tvalid_i[grant_id_q];
  assign lane_last  = s_axis_tlast_i[grant_id_q];
  assign lane_data  = s_axis_tdata_i[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign hs         = in_grant & lane_valid & m_axis_tready_i;

  // Scan from farthest to nearest offset so the nearest valid lane wins.
  always_comb begin
    pick = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int k;
      k = (int'(ptr_q) + i) % N_REQ;
      if (s_axis_tvalid_i[k]) pick = IW'(k);
    end
  end

`ifdef AXIS_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q + 1'b1;
    if (!in_grant || hs) stall_d = '0;
  end

  // Abort on the TIMEOUT_CYCLES-th consecutive cycle without a handshake.
  assign stall_abort = in_grant & ~hs &
                       (stall_q == SW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) stall_q <= '0;
    else          stall_q <= stall_d;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign stall_abort = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      gap_q      <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    gap_d      = gap_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (!i2c_busy_i && |s_axis_tvalid_i) begin
          grant_id_d = pick;
          state_d    = S_GRANT;
        end
      end
      (state_q == S_GRANT): begin
        if ((hs && lane_last) || stall_abort) begin
          ptr_d   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
          gap_d   = '0;
          state_d = S_HOLD;
        end
      end
      (state_q == S_HOLD): begin
        if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
        else if (!i2c_busy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_axis_tdata_o  = '0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;
    s_axis_tready_o = '0;
    if (in_grant) begin
      m_axis_tdata_o              = lane_data;
      m_axis_tvalid_o             = lane_valid;
      m_axis_tlast_o              = lane_last;
      s_axis_tready_o[grant_id_q] = m_axis_tready_i;
    end
  end

  assign grant_id_o     = grant_id_q;
  assign grant_active_o = in_grant;
  assign timeout_o      = stall_abort;

endmodule

// File: tb/tb_axis_i2c_req_arbiter.sv
// Bench for axis_i2c_req_arbiter: directed scenarios plus random traffic
// against a transaction-level round-robin model.

module tb_axis_i2c_req_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int GAP = 4;
  localparam int TO  = 16;
  localparam int IW  = $clog2(N);
  localparam int BIG = 1 << 30;

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } beat_t;

  logic            clk = 1'b0;
  logic            arstn_i;
  logic [N*DW-1:0] s_axis_tdata_i;
  logic [N-1:0]    s_axis_tvalid_i;
  logic [N-1:0]    s_axis_tlast_i;
  logic [N-1:0]    s_axis_tready_o;
  logic [DW-1:0]   m_axis_tdata_o;
  logic            m_axis_tvalid_o;
  logic            m_axis_tlast_o;
  logic            m_axis_tready_i;
  logic            i2c_busy_i;
  logic [IW-1:0]   grant_id_o;
  logic            grant_active_o;
  logic            timeout_o;

  always #5 clk = ~clk;

  axis_i2c_req_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .arstn_i(arstn_i),
    .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i),
    .s_axis_tlast_i(s_axis_tlast_i), .s_axis_tready_o(s_axis_tready_o),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tready_i(m_axis_tready_i),
    .i2c_busy_i(i2c_busy_i), .grant_id_o(grant_id_o),
    .grant_active_o(grant_active_o), .timeout_o(timeout_o)
  );

  int checks, failures, cyc;
  beat_t lq[N][$];
  logic [N-1:0] hide;
  logic rst_k, busy_k, rdy_k;

  // reference model: who holds the port, rotation pointer, gap bookkeeping
  bit m_gr;
  int m_id, m_ptr, m_stall, t_last, idle_from;

  // what the DUT actually did
  bit prev_ga;
  int d_glog[$], d_gtime[$], d_hcyc[$];
  int d_to, d_tocyc;
  beat_t d_out[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int o = 0; o < N; o++)
      if (v[(p + o) % N]) return (p + o) % N;
    return p;
  endfunction

  task automatic end_grant();
    m_gr      = 0;
    t_last    = cyc;
    idle_from = BIG;
    m_ptr     = (m_id + 1) % N;
  endtask

  task automatic step();
    logic [N-1:0]  v, el, es;
    logic [DW-1:0] ed [N];
    logic          eto;
    @(negedge clk);
    cyc++;
    arstn_i         = rst_k;
    m_axis_tready_i = rdy_k;
    i2c_busy_i      = busy_k;
    for (int k = 0; k < N; k++) begin
      ed[k] = (lq[k].size() > 0) ? lq[k][0].d : '0;
      el[k] = (lq[k].size() > 0) ? lq[k][0].l : 1'b0;
      v[k]  = (lq[k].size() > 0) && !hide[k];
      s_axis_tdata_i[k*DW +: DW] = ed[k];
      s_axis_tlast_i[k]  = el[k];
      s_axis_tvalid_i[k] = v[k];
    end
    #1;
    if (grant_active_o && !prev_ga) begin
      d_glog.push_back(int'(grant_id_o));
      d_gtime.push_back(cyc);
    end
    if (m_axis_tvalid_o && m_axis_tready_i) begin
      d_out.push_back({m_axis_tlast_o, m_axis_tdata_o});
      d_hcyc.push_back(cyc);
    end
    if (timeout_o) begin
      d_to++;
      d_tocyc = cyc;
    end
    eto = 1'b0;
    if (!rst_k || !m_gr) begin
      chk("gactive", grant_active_o, 0);
      chk("mvalid", m_axis_tvalid_o, 0);
      chk("mdata", m_axis_tdata_o, 0);
      chk("mlast", m_axis_tlast_o, 0);
      chk("sready", s_axis_tready_o, 0);
      if (!rst_k) begin
        chk("rst_gid", grant_id_o, 0);
        m_gr = 0; m_ptr = 0; m_stall = 0;
        t_last = -1000; idle_from = cyc + 1;
      end else if (idle_from == BIG) begin
        if (cyc >= t_last + GAP && !busy_k) idle_from = cyc + 1;
      end else if (cyc >= idle_from && !busy_k && v != '0) begin
        m_gr = 1; m_id = rr_pick(v, m_ptr); m_stall = 0;
      end
    end else begin
      es = '0;
      es[m_id] = rdy_k;
      chk("gactive", grant_active_o, 1);
      chk("gid", grant_id_o, m_id);
      chk("mvalid", m_axis_tvalid_o, v[m_id]);
      chk("mdata", m_axis_tdata_o, ed[m_id]);
      chk("mlast", m_axis_tlast_o, el[m_id]);
      chk("sready", s_axis_tready_o, es);
      if (v[m_id] && rdy_k) begin
        void'(lq[m_id].pop_front());
        m_stall = 0;
        if (el[m_id]) end_grant();
      end else begin
`ifdef AXIS_ARB_TIMEOUT_EN
        m_stall++;
        if (m_stall == TO) begin
          eto = 1'b1;
          end_grant();
        end
`endif
      end
    end
    chk("timeout", timeout_o, eto);
    prev_ga = grant_active_o;
  endtask

  task automatic push(int k, logic [DW-1:0] d, logic l);
    lq[k].push_back({l, d});
  endtask

  task automatic push_pkt(int k);
    int len;
    len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++)
      push(k, DW'($urandom), i == len - 1);
  endtask

  task automatic clr_logs();
    d_glog.delete(); d_gtime.delete(); d_hcyc.delete(); d_out.delete();
    d_to = 0;
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (lq[k].size() > 0) return 1;
    return m_gr;
  endfunction

  task automatic drain(string tag);
    hide = '0; busy_k = 0; rdy_k = 1;
    for (int i = 0; i < 400 && pending(); i++) step();
    chk(tag, pending(), 0);
  endtask

  task automatic do_reset();
    rst_k = 0; step(); rst_k = 1;
  endtask

  int rc, n0;
  int exp_g[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    checks = 0; failures = 0; cyc = 0;
    hide = '0; rst_k = 0; busy_k = 0; rdy_k = 1;
    m_gr = 0; m_id = 0; m_ptr = 0; m_stall = 0;
    t_last = -1000; idle_from = 0; prev_ga = 0; d_to = 0; d_tocyc = 0;
    arstn_i = 0; m_axis_tready_i = 0; i2c_busy_i = 0;
    s_axis_tdata_i = '0; s_axis_tvalid_i = '0; s_axis_tlast_i = '0;
    step();
    rst_k = 1;

    // single requester, 3-beat packet then a 1-beat follow-up
    clr_logs();
    push(2, 16'h1234, 0); push(2, 16'h5678, 0); push(2, 16'h9ABC, 1);
    push(2, 16'h0F0F, 1);
    rc = cyc + 1;
    for (int i = 0; i < 40 && pending(); i++) step();
    chk("t1_id", d_glog[0], 2);
    chk("t1_lat", d_gtime[0] - rc, 1);
    chk("t1_b0", d_out[0], {1'b0, 16'h1234});
    chk("t1_b1", d_out[1], {1'b0, 16'h5678});
    chk("t1_b2", d_out[2], {1'b1, 16'h9ABC});
    chk("t1_gap", d_gtime[1] - d_hcyc[2], GAP + 2);

    // three lanes always valid, single-beat packets
    do_reset(); clr_logs();
    for (int r = 0; r < 2; r++) begin
      push(0, DW'(r), 1); push(1, DW'(16 + r), 1); push(3, DW'(48 + r), 1);
    end
    for (int i = 0; i < 100 && pending(); i++) step();
    chk("t2_cnt", d_glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_g%0d", i), d_glog[i], exp_g[i]);
      chk($sformatf("t2_d%0d", i), d_out[i].d, DW'(exp_g[i]*16 + i/3));
    end

    // busy blocks the next grant
    clr_logs();
    push(0, 16'hA5A5, 1);
    for (int i = 0; i < 30 && lq[0].size() > 0; i++) step();
    busy_k = 1;
    push(1, 16'h1111, 1);
    n0 = d_glog.size();
    for (int i = 0; i < 20; i++) step();
    chk("t3_hold", d_glog.size(), n0);
    busy_k = 0;
    rc = cyc + 1;
    for (int i = 0; i < 20 && d_glog.size() <= n0; i++) step();
    chk("t3_id", d_glog[n0], 1);
    chk("t3_lat", d_gtime[n0] - rc, 2);
    drain("t3_drain");

    // downstream ready toggling during a 4-beat packet
    clr_logs();
    for (int i = 0; i < 4; i++) push(0, DW'(16'hC000 + i), i == 3);
    for (int i = 0; i < 60 && pending(); i++) begin
      rdy_k = (i % 2 == 0);
      step();
    end
    rdy_k = 1;
    chk("t4_cnt", d_out.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_b%0d", i), d_out[i], {i == 3, DW'(16'hC000 + i)});

    // reset mid-packet returns the pointer to lane 0
    clr_logs();
    push(2, 16'h2222, 1);
    for (int i = 0; i < 4; i++) push(0, DW'(16'hD000 + i), i == 3);
    for (int i = 0; i < 40 && lq[0].size() > 2; i++) step();
    push(3, 16'h3333, 1);
    do_reset();
    n0 = d_glog.size();
    for (int i = 0; i < 20 && d_glog.size() <= n0; i++) step();
    chk("t5_id", d_glog[n0], 0);
    drain("t5_drain");

`ifdef AXIS_ARB_TIMEOUT_EN
    // granted lane stalls mid-packet until the abort fires
    do_reset(); clr_logs();
    for (int i = 0; i < 3; i++) push(0, DW'(16'hE000 + i), i == 2);
    push(1, 16'h1A1A, 1);
    for (int i = 0; i < 20 && lq[0].size() > 2; i++) step();
    hide[0] = 1;
    for (int i = 0; i < 60 && d_glog.size() < 2; i++) step();
    chk("t6_pulses", d_to, 1);
    chk("t6_when", d_tocyc - d_hcyc[0], TO);
    chk("t6_next", d_glog[1], 1);
    drain("t6_drain");
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < N; k++) begin
        if (lq[k].size() == 0 && $urandom_range(0, 3) == 0) push_pkt(k);
        hide[k] = ($urandom_range(0, 9) == 0);
      end
      busy_k = ($urandom_range(0, 4) == 0);
      rdy_k  = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_i2c_req_arbiter.md
# axis_i2c_req_arbiter

Round-robin arbiter that shares the single AXI-Stream command input of the I2C master among `N_REQ` independent requesters (config sequencer, CPU bridge, sensor pollers). It grants one requester at a time, passes its whole packet (up to `tlast`) through unbroken, and waits for the I2C master to go idle before granting again. It sits directly in front of the I2C top's `s_axis` port, on the main clock.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `DATA_WIDTH`, 16: AXIS word width ({reg addr, reg data}), matching the I2C top
- `GAP_CYCLES`, 4: minimum idle cycles in HOLD after a packet's last beat
- `TIMEOUT_CYCLES`, 1024: stall limit for a granted packet (used only with `AXIS_ARB_TIMEOUT_EN`)

Ports:
- `clk_i` in 1: main clock
- `arstn_i` in 1: asynchronous active-low reset
- `s_axis_tdata_i` in N_REQ*DATA_WIDTH: requester data, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `s_axis_tvalid_i` in N_REQ: per-requester valid
- `s_axis_tlast_i` in N_REQ: per-requester last
- `s_axis_tready_o` out N_REQ: per-requester ready
- `m_axis_tdata_o` out DATA_WIDTH: to I2C master
- `m_axis_tvalid_o` out 1
- `m_axis_tlast_o` out 1
- `m_axis_tready_i` in 1
- `i2c_busy_i` in 1: I2C master transaction in progress
- `grant_id_o` out $clog2(N_REQ): index of current/last granted requester
- `grant_active_o` out 1: high in GRANT
- `timeout_o` out 1: one-cycle pulse on stall abort

## Operation
- FSM states: IDLE, GRANT, HOLD.
- IDLE: when `i2c_busy_i`=0 and any `s_axis_tvalid_i` high, pick first valid index at or after round-robin pointer `ptr` (wrapping N_REQ-1 -> 0); register it into `grant_id_o`; go GRANT. If `i2c_busy_i`=1, stay IDLE regardless of requests.
- GRANT: pure combinational pass-through of granted lane: `m_axis_tdata/tvalid/tlast` = lane `grant_id_o`; `s_axis_tready_o[grant_id_o]` = `m_axis_tready_i`; all other ready bits 0. On handshake with `m_axis_tlast_o`=1: `ptr` <= grant_id+1 mod N_REQ, go HOLD.
- HOLD: counter loads 0 on entry, counts to `GAP_CYCLES`-1; exit to IDLE on first cycle with counter saturated and `i2c_busy_i`=0. All ready 0, `m_axis_tvalid_o`=0.
- Non-granted requesters are never dropped; they keep tvalid asserted and are served in rotation order.
- Outside GRANT: `m_axis_tvalid_o`=0, `m_axis_tdata_o`=0, `m_axis_tlast_o`=0, all `s_axis_tready_o`=0.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant_id_o`=0, `grant_active_o`=0, `timeout_o`=0, all ready/valid/last/data outputs 0.
- Request in IDLE at cycle t (busy low) -> `grant_active_o` and `m_axis_tvalid_o` at t+1; first beat transfers at t+1 if `m_axis_tready_i`=1.
- Zero added latency per beat inside GRANT; full throughput.
- After last beat at cycle t: HOLD from t+1; earliest next grant visible at t+GAP_CYCLES+2.
- Single-beat packet (tvalid & tlast same cycle) handled identically.
- Granted lane drops tvalid mid-packet: arbiter stays in GRANT, output tvalid follows input.
- Reset asserted mid-packet: immediate return to reset values; partial packet is abandoned, no completion.

## Configuration
- `AXIS_ARB_TIMEOUT_EN` defined: in GRANT a stall counter increments each cycle without a handshake and clears on every handshake; reaching `TIMEOUT_CYCLES` pulses `timeout_o` for one cycle, advances `ptr` past the offender, enters HOLD. Residual beats of that packet are accepted only on its next grant.
- Not defined: no counter; `timeout_o` tied 0; GRANT held until tlast indefinitely.

## Test plan
- Only req 2 valid, 3-beat packet 0x1234, 0x5678, 0x9ABC (last), ready=1 -> grant_id=2 one cycle later, three beats out in order, tlast on 0x9ABC, HOLD 4 cycles, IDLE.
- Reqs 0,1,3 all valid continuously, 1-beat packets -> grant order 0,1,3,0,1,3; no beat from a non-granted lane appears on m_axis.
- `i2c_busy_i`=1 for 20 cycles after a packet while req 1 waits -> no grant until busy low and GAP elapsed; then grant_id=1.
- Downstream ready toggling 1,0,1,0 during 4-beat packet -> data unchanged while stalled, exactly 4 handshakes, source ready mirrors m_axis_tready.
- arstn_i low for 1 cycle mid-packet on req 0 -> all outputs 0 next edge, ptr=0, next grant goes to lowest valid index.
- With `AXIS_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=16: req 0 granted then drops tvalid before tlast -> timeout_o pulses at 16th stall cycle, req 1 (valid) granted after HOLD.
